// File: rtl/rx_sync_ctrl_pkg.sv
// RX sync control: shared PCS defines (lane count, state encodings)
// plus the types and helpers used by the sync FSM and its shared timer.

`ifndef PCS_DEFINES_SVH
`define PCS_DEFINES_SVH
`define LANENUMBER      4
`define PCS_ST_HUNT     3'd0
`define PCS_ST_QUALIFY  3'd1
`define PCS_ST_SYNC     3'd2
`define PCS_ST_FLUSH    3'd3
`endif

package rx_sync_ctrl_pkg;

   localparam int LANES = `LANENUMBER;

   typedef enum logic [2:0] {
      ST_HUNT    = `PCS_ST_HUNT,
      ST_QUALIFY = `PCS_ST_QUALIFY,
      ST_SYNC    = `PCS_ST_SYNC,
      ST_FLUSH   = `PCS_ST_FLUSH
   } sync_state_e;

   typedef enum logic [1:0] {
      TMR_HOLD  = 2'd0,
      TMR_LOAD1 = 2'd1,
      TMR_INC   = 2'd2,
      TMR_CLR   = 2'd3
   } tmr_cmd_e;

   // True when the increment about to happen would reach the limit,
   // so the FSM can leave its state on the same edge the count lands.
   function automatic logic cnt_hits(input logic [7:0] cnt, input int limit);
      return (({1'b0, cnt} + 9'd1) >= 9'(limit));
   endfunction

endpackage

// File: rtl/rx_sync_timer.sv
// Shared 8-bit timer for qualify, unlock-tolerance and flush timing.
// The FSM owns it through a load/increment/clear command.

module rx_sync_timer
   import rx_sync_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  tmr_cmd_e   cmd,
   output logic [7:0] count
);

   logic [7:0] count_reg;

   // Apply the FSM command; HOLD keeps the value across invalid cycles
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else begin
         case (cmd)
            TMR_LOAD1: count_reg <= 8'd1;
            TMR_INC:   count_reg <= count_reg + 8'd1;
            TMR_CLR:   count_reg <= '0;
            default:   count_reg <= count_reg;
         endcase
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/rx_sync_ctrl.sv
// RX sync controller: qualifies all-lane block lock before enabling the
// RX pipeline, tolerates short lock drops, and flushes on sync loss.

module rx_sync_ctrl
   import rx_sync_ctrl_pkg::*;
#(
   parameter int LOCK_WAIT    = 64,
   parameter int UNLOCK_TOL   = 4,
   parameter int FLUSH_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [`LANENUMBER-1:0] in_blocklock,
   input  logic                   in_rxdata_valid,
   input  logic                   in_clr_sticky,
   output logic                   out_stage_enable,
   output logic                   out_allsync,
   output logic                   out_flush,
   output logic [2:0]             out_state,
   output logic [`LANENUMBER-1:0] out_lane_lost,
   output logic [7:0]             out_loss_cnt
);

   sync_state_e            state_reg, state_next;
   sync_state_e            out_state_reg;
   tmr_cmd_e               tmr_cmd;
   logic [7:0]             tmr_count;
   logic                   loss_evt;
   logic                   alllock;
   logic                   out_allsync_reg;
   logic                   out_flush_reg;
   logic [`LANENUMBER-1:0] lane_set;
   logic [`LANENUMBER-1:0] lane_lost_reg;
   logic [7:0]             loss_cnt_reg;

   assign alllock = &in_blocklock;

   rx_sync_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd     (tmr_cmd),
      .count   (tmr_count)
   );

   // Next-state and timer command decode; only valid cycles advance, except FLUSH
   always_comb begin
      state_next = state_reg;
      tmr_cmd    = TMR_HOLD;
      loss_evt   = 1'b0;
      case (state_reg)
         ST_HUNT: begin
            if (in_rxdata_valid && alllock) begin
               if (LOCK_WAIT <= 1) begin
                  state_next = ST_SYNC;
                  tmr_cmd    = TMR_CLR;
               end else begin
                  state_next = ST_QUALIFY;
                  tmr_cmd    = TMR_LOAD1;
               end
            end
         end
         ST_QUALIFY: begin
            if (in_rxdata_valid) begin
               if (!alllock) begin
                  state_next = ST_HUNT;
                  tmr_cmd    = TMR_CLR;
               end else if (cnt_hits(tmr_count, LOCK_WAIT)) begin
                  state_next = ST_SYNC;
                  tmr_cmd    = TMR_CLR;
               end else begin
                  tmr_cmd    = TMR_INC;
               end
            end
         end
         ST_SYNC: begin
            if (in_rxdata_valid) begin
               if (alllock) begin
                  tmr_cmd    = TMR_CLR;
               end else if (cnt_hits(tmr_count, UNLOCK_TOL)) begin
                  state_next = ST_FLUSH;
                  tmr_cmd    = TMR_CLR;
                  loss_evt   = 1'b1;
               end else begin
                  tmr_cmd    = TMR_INC;
               end
            end
         end
         ST_FLUSH: begin
            if (cnt_hits(tmr_count, FLUSH_CYCLES)) begin
               state_next = ST_HUNT;
               tmr_cmd    = TMR_CLR;
            end else begin
               tmr_cmd    = TMR_INC;
            end
         end
         default: begin
            state_next = ST_HUNT;
            tmr_cmd    = TMR_CLR;
         end
      endcase
   end

   // FSM state plus registered status outputs, trailing the state by one cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= ST_HUNT;
         out_state_reg   <= ST_HUNT;
         out_allsync_reg <= 1'b0;
         out_flush_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         out_state_reg   <= state_reg;
         out_allsync_reg <= (state_reg == ST_SYNC);
         out_flush_reg   <= (state_reg == ST_FLUSH);
      end
   end

   // A lane counts as lost whenever it is unlocked while in SYNC, valid or not
   genvar gi;
   generate
      for (gi = 0; gi < `LANENUMBER; gi++) begin : g_lane_set
         assign lane_set[gi] = (state_reg == ST_SYNC) && !in_blocklock[gi];
      end
   endgenerate

   // Sticky lane flags and saturating loss counter; a new event beats a clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lane_lost_reg <= '0;
         loss_cnt_reg  <= '0;
      end else begin
         lane_lost_reg <= (in_clr_sticky ? '0 : lane_lost_reg) | lane_set;
         if (loss_evt) begin
            if (in_clr_sticky)
               loss_cnt_reg <= 8'd1;
            else if (loss_cnt_reg != 8'hFF)
               loss_cnt_reg <= loss_cnt_reg + 8'd1;
         end else if (in_clr_sticky) begin
            loss_cnt_reg <= '0;
         end
      end
   end

   assign out_stage_enable = (out_state_reg == ST_FLUSH) ? 1'b1 : in_rxdata_valid;
   assign out_allsync      = out_allsync_reg;
   assign out_flush        = out_flush_reg;
   assign out_state        = out_state_reg;
   assign out_lane_lost    = lane_lost_reg;
   assign out_loss_cnt     = loss_cnt_reg;

endmodule
